// File: rtl/dqn_pkg.sv
// dqn_pkg: layer widths, Q6.10 data type and backward-pass FSM states shared by the DQN blocks.
package dqn_pkg;

  localparam int N_IN  = 9;
  localparam int N_HID = 5;
  localparam int N_OUT = 4;
  localparam int FRAC  = 10;

  typedef logic signed [15:0] q6_10_t;

  localparam q6_10_t ONE   = 16'sh0400;
  localparam q6_10_t Q_MAX = 16'sh7FFF;
  localparam q6_10_t Q_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    OUT  = 3'd2,
    HID  = 3'd3,
    INP  = 3'd4,
    DONE = 3'd5
  } bp_state_t;

  // Clamp a 17-bit signed difference into Q6.10 range.
  function automatic q6_10_t sat17(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      sat17 = v[16] ? Q_MIN : Q_MAX;
    end else begin
      sat17 = v[15:0];
    end
  endfunction

endpackage

// File: rtl/bp_fxp_mul.sv
// bp_fxp_mul: signed Q6.10 multiply, rescale to Q6.10, then arithmetic right shift by i_shift.
// With BACK_PROP_SAT_EN defined the rescaled slice saturates instead of wrapping.
module bp_fxp_mul
  import dqn_pkg::*;
(
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  input  logic [3:0]         i_shift,
  output logic signed [15:0] o_p
);

  logic signed [31:0] w_prod;
  logic signed [15:0] w_slice;
  logic               w_unused;

  assign w_prod   = i_a * i_b;
  assign w_unused = ^{w_prod[31:FRAC+16], w_prod[FRAC-1:0]};

`ifdef BACK_PROP_SAT_EN
  // Saturate when the bits above the slice are not a pure sign extension of it.
  always_comb begin
    if (w_prod[31:FRAC+15] == {(17-FRAC){w_prod[FRAC+15]}}) begin
      w_slice = w_prod[FRAC+15:FRAC];
    end else if (w_prod[31]) begin
      w_slice = Q_MIN;
    end else begin
      w_slice = Q_MAX;
    end
  end
`else
  assign w_slice = w_prod[FRAC+15:FRAC];
`endif

  assign o_p = w_slice >>> i_shift;

endmodule

// File: rtl/back_prop.sv
// back_prop: backward pass of the 9-5-4 DQN MLP, producing lr-scaled weight/bias deltas row by row.
// Define BACK_PROP_SAT_EN to saturate the error subtract and every product slice instead of wrapping.
module back_prop
  import dqn_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [1:0]                i_action,
  input  logic [15:0]               i_target,
  input  logic [3:0]                i_lr_shift,
  input  logic [N_IN*16-1:0]        i_x_bus,
  input  logic [N_HID*16-1:0]       i_a2_bus,
  input  logic [N_OUT*16-1:0]       i_a3_bus,
  input  logic [N_HID*N_OUT*16-1:0] i_w3_bus,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [N_IN*N_HID*16-1:0]  o_deltaw2_bus,
  output logic [N_HID*16-1:0]       o_deltab2_bus,
  output logic [N_HID*N_OUT*16-1:0] o_deltaw3_bus,
  output logic [N_OUT*16-1:0]       o_deltab3_bus
);

  localparam int N_MUL = N_HID;

  bp_state_t r_state;
  bp_state_t w_state_nxt;
  logic      w_row_last;

  logic [3:0]                r_row;
  logic [1:0]                r_act;
  q6_10_t                    r_target;
  logic [3:0]                r_lr;
  logic [N_IN*16-1:0]        r_x_bus;
  logic [N_HID*16-1:0]       r_a2_bus;
  logic [N_OUT*16-1:0]       r_a3_bus;
  logic [N_HID*N_OUT*16-1:0] r_w3_bus;
  q6_10_t                    r_d3 [N_OUT];
  q6_10_t                    r_d2 [N_HID];
  logic                      r_busy;
  logic                      r_done;
  logic [N_IN*N_HID*16-1:0]  r_dw2_bus;
  logic [N_HID*16-1:0]       r_db2_bus;
  logic [N_HID*N_OUT*16-1:0] r_dw3_bus;
  logic [N_OUT*16-1:0]       r_db3_bus;

  q6_10_t             w_a2_row;
  q6_10_t             w_x_row;
  q6_10_t             w_a3_act;
  q6_10_t             w_w3_act;
  logic signed [16:0] w_err_full;
  q6_10_t             w_err;
  q6_10_t             w_d2;
  q6_10_t             w_ma [N_MUL];
  q6_10_t             w_mb [N_MUL];
  q6_10_t             w_mp [N_MUL];
  logic [3:0]         w_msh;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the row counter wraps at the end of each row phase.
  always_comb begin
    w_state_nxt = r_state;
    w_row_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !r_busy) begin
          w_state_nxt = ERR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ERR: w_state_nxt = OUT;
      OUT: begin
        w_row_last  = (r_row == 4'(N_HID - 1));
        w_state_nxt = w_row_last ? HID : OUT;
      end
      HID: begin
        w_row_last  = (r_row == 4'(N_HID - 1));
        w_state_nxt = w_row_last ? INP : HID;
      end
      INP: begin
        w_row_last  = (r_row == 4'(N_IN - 1));
        w_state_nxt = w_row_last ? DONE : INP;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select the operands addressed by the current row and the latched action.
  always_comb begin
    w_a2_row = 16'sd0;
    w_x_row  = 16'sd0;
    w_a3_act = 16'sd0;
    w_w3_act = 16'sd0;
    for (int i = 0; i < N_HID; i++) begin
      w_a2_row = (r_row == 4'(i)) ? r_a2_bus[16*i +: 16] : w_a2_row;
    end
    for (int k = 0; k < N_IN; k++) begin
      w_x_row = (r_row == 4'(k)) ? r_x_bus[16*k +: 16] : w_x_row;
    end
    for (int j = 0; j < N_OUT; j++) begin
      w_a3_act = (r_act == 2'(j)) ? r_a3_bus[16*j +: 16] : w_a3_act;
    end
    for (int i = 0; i < N_HID; i++) begin
      for (int j = 0; j < N_OUT; j++) begin
        w_w3_act = ((r_row == 4'(i)) && (r_act == 2'(j))) ?
                   r_w3_bus[16*(i*N_OUT+j) +: 16] : w_w3_act;
      end
    end
  end

  assign w_err_full = {r_target[15], r_target} - {w_a3_act[15], w_a3_act};

`ifdef BACK_PROP_SAT_EN
  assign w_err = sat17(w_err_full);
`else
  logic w_err_unused;
  assign w_err        = w_err_full[15:0];
  assign w_err_unused = w_err_full[16];
`endif

  // ReLU derivative on the hidden layer gates the back-propagated error.
  assign w_d2 = (w_a2_row > 16'sd0) ? w_mp[0] : 16'sd0;

  // Multiplier operand routing; HID reuses lane 0 with no learning-rate shift.
  always_comb begin
    for (int m = 0; m < N_MUL; m++) begin
      w_ma[m] = 16'sd0;
      w_mb[m] = 16'sd0;
    end
    w_msh = r_lr;
    case (r_state)
      OUT: begin
        for (int j = 0; j < N_OUT; j++) begin
          w_ma[j] = r_d3[j];
          w_mb[j] = w_a2_row;
        end
      end
      HID: begin
        w_ma[0] = w_w3_act;
        w_mb[0] = r_d3[r_act];
        w_msh   = 4'd0;
      end
      INP: begin
        for (int i = 0; i < N_HID; i++) begin
          w_ma[i] = r_d2[i];
          w_mb[i] = w_x_row;
        end
      end
      default: w_msh = r_lr;
    endcase
  end

  for (genvar m = 0; m < N_MUL; m++) begin : g_mul
    bp_fxp_mul u_mul (
      .i_a     (w_ma[m]),
      .i_b     (w_mb[m]),
      .i_shift (w_msh),
      .o_p     (w_mp[m])
    );
  end

  // Datapath: latch operands on launch, then write one row of deltas per cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row     <= 4'd0;
      r_act     <= 2'd0;
      r_target  <= 16'sd0;
      r_lr      <= 4'd0;
      r_x_bus   <= '0;
      r_a2_bus  <= '0;
      r_a3_bus  <= '0;
      r_w3_bus  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dw2_bus <= '0;
      r_db2_bus <= '0;
      r_dw3_bus <= '0;
      r_db3_bus <= '0;
      for (int j = 0; j < N_OUT; j++) r_d3[j] <= 16'sd0;
      for (int i = 0; i < N_HID; i++) r_d2[i] <= 16'sd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_done) begin
            r_busy <= 1'b0;
          end
          if (i_start && !r_busy) begin
            r_busy   <= 1'b1;
            r_row    <= 4'd0;
            r_act    <= i_action;
            r_target <= i_target;
            r_lr     <= i_lr_shift;
            r_x_bus  <= i_x_bus;
            r_a2_bus <= i_a2_bus;
            r_a3_bus <= i_a3_bus;
            r_w3_bus <= i_w3_bus;
          end
        end
        ERR: begin
          for (int j = 0; j < N_OUT; j++) begin
            r_d3[j] <= ((r_act == 2'(j)) && (w_a3_act > 16'sd0)) ? w_err : 16'sd0;
          end
        end
        OUT: begin
          for (int i = 0; i < N_HID; i++) begin
            if (r_row == 4'(i)) begin
              for (int j = 0; j < N_OUT; j++) begin
                r_dw3_bus[16*(i*N_OUT+j) +: 16] <= w_mp[j];
              end
            end
          end
          if (r_row == 4'd0) begin
            for (int j = 0; j < N_OUT; j++) begin
              r_db3_bus[16*j +: 16] <= r_d3[j] >>> r_lr;
            end
          end
          r_row <= w_row_last ? 4'd0 : r_row + 4'd1;
        end
        HID: begin
          for (int i = 0; i < N_HID; i++) begin
            if (r_row == 4'(i)) begin
              r_d2[i]               <= w_d2;
              r_db2_bus[16*i +: 16] <= w_d2 >>> r_lr;
            end
          end
          r_row <= w_row_last ? 4'd0 : r_row + 4'd1;
        end
        INP: begin
          for (int k = 0; k < N_IN; k++) begin
            if (r_row == 4'(k)) begin
              for (int i = 0; i < N_HID; i++) begin
                r_dw2_bus[16*(k*N_HID+i) +: 16] <= w_mp[i];
              end
            end
          end
          r_row <= w_row_last ? 4'd0 : r_row + 4'd1;
        end
        DONE: r_done <= 1'b1;
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_deltaw2_bus = r_dw2_bus;
  assign o_deltab2_bus = r_db2_bus;
  assign o_deltaw3_bus = r_dw3_bus;
  assign o_deltab3_bus = r_db3_bus;

endmodule

// File: tb/tb_back_prop.sv
// tb_back_prop: directed vectors with hand-computed deltas for the DQN backward pass.
module tb_back_prop;
  import dqn_pkg::*;

  logic                      clk;
  logic                      rst;
  logic                      start;
  logic [1:0]                action;
  logic [15:0]               target;
  logic [3:0]                lr_shift;
  logic [N_IN*16-1:0]        x_bus;
  logic [N_HID*16-1:0]       a2_bus;
  logic [N_OUT*16-1:0]       a3_bus;
  logic [N_HID*N_OUT*16-1:0] w3_bus;
  logic                      busy;
  logic                      done;
  logic [N_IN*N_HID*16-1:0]  deltaw2_bus;
  logic [N_HID*16-1:0]       deltab2_bus;
  logic [N_HID*N_OUT*16-1:0] deltaw3_bus;
  logic [N_OUT*16-1:0]       deltab3_bus;

  int n_checks = 0;
  int n_fail   = 0;

  back_prop dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_action      (action),
    .i_target      (target),
    .i_lr_shift    (lr_shift),
    .i_x_bus       (x_bus),
    .i_a2_bus      (a2_bus),
    .i_a3_bus      (a3_bus),
    .i_w3_bus      (w3_bus),
    .o_busy        (busy),
    .o_done        (done),
    .o_deltaw2_bus (deltaw2_bus),
    .o_deltab2_bus (deltab2_bus),
    .o_deltaw3_bus (deltaw3_bus),
    .o_deltab3_bus (deltab3_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dw3(input int i, input int j);
    return deltaw3_bus[16*((i-1)*N_OUT+(j-1)) +: 16];
  endfunction
  function automatic logic [15:0] db3(input int j);
    return deltab3_bus[16*(j-1) +: 16];
  endfunction
  function automatic logic [15:0] dw2(input int k, input int i);
    return deltaw2_bus[16*((k-1)*N_HID+(i-1)) +: 16];
  endfunction
  function automatic logic [15:0] db2(input int i);
    return deltab2_bus[16*(i-1) +: 16];
  endfunction

  task automatic set_x(input int k, input logic [15:0] v);
    x_bus[16*(k-1) +: 16] = v;
  endtask
  task automatic set_a2(input int i, input logic [15:0] v);
    a2_bus[16*(i-1) +: 16] = v;
  endtask
  task automatic set_a3(input int j, input logic [15:0] v);
    a3_bus[16*(j-1) +: 16] = v;
  endtask
  task automatic set_w3(input int i, input int j, input logic [15:0] v);
    w3_bus[16*((i-1)*N_OUT+(j-1)) +: 16] = v;
  endtask

  task automatic clear_inputs();
    action   = 2'd1;
    target   = 16'h0000;
    lr_shift = 4'd0;
    x_bus    = '0;
    a2_bus   = '0;
    a3_bus   = '0;
    w3_bus   = '0;
  endtask

  // Junk on every input once the pass has latched them.
  task automatic scramble_inputs();
    action   = 2'($urandom);
    target   = 16'($urandom);
    lr_shift = 4'($urandom);
    for (int k = 0; k < N_IN; k++) x_bus[16*k +: 16] = 16'($urandom);
    for (int i = 0; i < N_HID; i++) a2_bus[16*i +: 16] = 16'($urandom);
    for (int j = 0; j < N_OUT; j++) a3_bus[16*j +: 16] = 16'($urandom);
    for (int m = 0; m < N_HID*N_OUT; m++) w3_bus[16*m +: 16] = 16'($urandom);
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
  endtask

  task automatic run_pass(input string tag);
    int  n;
    bit  seen;
    launch();
    check_eq({tag, "_busy_start"}, 32'(busy), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_done_latency"}, 32'(n), 32'd21);
    check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_busy_clear"}, 32'(busy), 32'd0);
  endtask

  task automatic setup_t3(input logic [3:0] lr);
    clear_inputs();
    lr_shift = lr;
    target   = 16'h0800;
    set_a3(2, 16'h0400);
    set_a2(1, 16'h0400);
    set_w3(1, 2, 16'h0400);
    set_x(1, 16'h0400);
    set_x(2, 16'h0800);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int first;
    rst   = 1'b1;
    start = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_dw3", 32'(|deltaw3_bus), 32'd0);
    check_eq("rst_dw2", 32'(|deltaw2_bus), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // e = 0800-0400 = 0400; deltaw3_12 = 0400*0800 >> 10 = 0800
    clear_inputs();
    target = 16'h0800;
    set_a3(2, 16'h0400);
    set_a2(1, 16'h0800);
    run_pass("t2");
    check_eq("t2_db3_2", 32'(db3(2)), 32'h0400);
    check_eq("t2_db3_1", 32'(db3(1)), 32'h0000);
    check_eq("t2_dw3_12", 32'(dw3(1, 2)), 32'h0800);
    check_eq("t2_dw3_11", 32'(dw3(1, 1)), 32'h0000);
    check_eq("t2_dw3_14", 32'(dw3(1, 4)), 32'h0000);
    check_eq("t2_dw3_22", 32'(dw3(2, 2)), 32'h0000);
    check_eq("t2_dw2_all", 32'(|deltaw2_bus), 32'd0);

    setup_t3(4'd0);
    run_pass("t3a");
    check_eq("t3a_dw3_12", 32'(dw3(1, 2)), 32'h0400);
    check_eq("t3a_db2_1", 32'(db2(1)), 32'h0400);
    check_eq("t3a_dw2_11", 32'(dw2(1, 1)), 32'h0400);
    check_eq("t3a_dw2_21", 32'(dw2(2, 1)), 32'h0800);
    check_eq("t3a_dw2_12", 32'(dw2(1, 2)), 32'h0000);

    setup_t3(4'd2);
    run_pass("t3b");
    check_eq("t3b_db3_2", 32'(db3(2)), 32'h0100);
    check_eq("t3b_dw3_12", 32'(dw3(1, 2)), 32'h0100);
    check_eq("t3b_db2_1", 32'(db2(1)), 32'h0100);
    check_eq("t3b_dw2_11", 32'(dw2(1, 1)), 32'h0100);
    check_eq("t3b_dw2_21", 32'(dw2(2, 1)), 32'h0200);

    // Asynchronous reset between edges clears outputs at once.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("t1_async_dw2", 32'(|deltaw2_bus), 32'd0);
    check_eq("t1_async_db3", 32'(|deltab3_bus), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Negative a3[act]: ReLU derivative zero, every delta zero.
    setup_t3(4'd0);
    set_a3(2, 16'hFC00);
    run_pass("t4a");
    check_eq("t4a_db3", 32'(|deltab3_bus), 32'd0);
    check_eq("t4a_dw3", 32'(|deltaw3_bus), 32'd0);
    check_eq("t4a_dw2", 32'(|deltaw2_bus), 32'd0);

    // a2_1 = 0 gates hidden unit 1; unit 2 still propagates.
    setup_t3(4'd0);
    set_a2(1, 16'h0000);
    set_a2(2, 16'h0400);
    set_w3(2, 2, 16'h0400);
    run_pass("t4b");
    check_eq("t4b_dw3_12", 32'(dw3(1, 2)), 32'h0000);
    check_eq("t4b_dw3_22", 32'(dw3(2, 2)), 32'h0400);
    check_eq("t4b_db2_1", 32'(db2(1)), 32'h0000);
    check_eq("t4b_dw2_11", 32'(dw2(1, 1)), 32'h0000);
    check_eq("t4b_db2_2", 32'(db2(2)), 32'h0400);
    check_eq("t4b_dw2_12", 32'(dw2(1, 2)), 32'h0400);

    // d3 = 7000, a2_1 = 4000: product 1C000000 overflows the slice.
    clear_inputs();
    target = 16'h7400;
    set_a3(2, 16'h0400);
    set_a2(1, 16'h4000);
    run_pass("t5a");
    check_eq("t5a_db3_2", 32'(db3(2)), 32'h7000);
`ifdef BACK_PROP_SAT_EN
    check_eq("t5a_dw3_12", 32'(dw3(1, 2)), 32'h7FFF);
`else
    check_eq("t5a_dw3_12", 32'(dw3(1, 2)), 32'h0000);
`endif

    // -32.0 - 1.0 overflows the error subtract.
    clear_inputs();
    target = 16'h8000;
    set_a3(2, 16'h0400);
    run_pass("t5b");
`ifdef BACK_PROP_SAT_EN
    check_eq("t5b_db3_2", 32'(db3(2)), 32'h8000);
`else
    check_eq("t5b_db3_2", 32'(db3(2)), 32'h7C00);
`endif

    // e = -1.0, lr_shift 3: shifts round toward -inf.
    clear_inputs();
    lr_shift = 4'd3;
    set_a3(2, 16'h0400);
    set_a2(1, 16'h0001);
    set_w3(1, 2, 16'h0400);
    set_x(1, 16'h0400);
    run_pass("tneg");
    check_eq("tneg_db3_2", 32'(db3(2)), 32'hFF80);
    check_eq("tneg_dw3_12", 32'(dw3(1, 2)), 32'hFFFF);
    check_eq("tneg_db2_1", 32'(db2(1)), 32'hFF80);
    check_eq("tneg_dw2_11", 32'(dw2(1, 1)), 32'hFF80);

    clear_inputs();
    lr_shift = 4'd15;
    set_a3(2, 16'h0400);
    run_pass("tlr15");
    check_eq("tlr15_db3_2", 32'(db3(2)), 32'hFFFF);

    // Starts while busy (mid-pass and on the done cycle) are ignored.
    setup_t3(4'd0);
    launch();
    cnt   = 0;
    first = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cnt++;
        if (first == 0) first = n;
      end
      start = (n == 4 || n == 21) ? 1'b1 : 1'b0;
    end
    check_eq("t6_done_count", 32'(cnt), 32'd1);
    check_eq("t6_done_cycle", 32'(first), 32'd21);
    check_eq("t6_dw3_12", 32'(dw3(1, 2)), 32'h0400);
    check_eq("t6_dw2_11", 32'(dw2(1, 1)), 32'h0400);
    check_eq("t6_busy_idle", 32'(busy), 32'd0);

    // Reset at cycle 8 of a pass.
    setup_t3(4'd0);
    launch();
    repeat (8) @(posedge clk);
    #1;
    check_eq("t6r_pre_dw3", 32'(|deltaw3_bus), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("t6r_busy", 32'(busy), 32'd0);
    check_eq("t6r_done", 32'(done), 32'd0);
    check_eq("t6r_dw3", 32'(|deltaw3_bus), 32'd0);
    check_eq("t6r_db3", 32'(|deltab3_bus), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check_eq("t6r_no_done", 32'(cnt), 32'd0);
    setup_t3(4'd0);
    run_pass("t6r_rerun");
    check_eq("t6r_rerun_db3_2", 32'(db3(2)), 32'h0400);
    check_eq("t6r_rerun_dw2_21", 32'(dw2(2, 1)), 32'h0800);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
